// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment digit driver: anode codes,
// the blank segment pattern, the hex glyph table and anode decoding.
package seven_seg_pkg;

   // Active-low one-cold anode codes; bit 0 is the rightmost digit.
   localparam logic [3:0] DIG0    = 4'b1110;
   localparam logic [3:0] DIG1    = 4'b1101;
   localparam logic [3:0] DIG2    = 4'b1011;
   localparam logic [3:0] DIG3    = 4'b0111;
   localparam logic [3:0] ALL_OFF = 4'b1111;

   // All segments dark, active-low {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // NOTE: this is a constant table, so it becomes pure decode logic;
   // unlike a writable memory it has nothing to reset.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

   // Decoded anode code: which digit is being scanned, and whether the code
   // was legal at all.
   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } digit_sel_t;

   // Map a scanner anode code to a digit index; anything that is not
   // exactly one zero bit is flagged invalid.
   function automatic digit_sel_t decode_anode(input logic [3:0] code);
      digit_sel_t sel;
      sel = '{valid: 1'b0, idx: 2'd0};
      case (code)
         DIG0:    sel = '{valid: 1'b1, idx: 2'd0};
         DIG1:    sel = '{valid: 1'b1, idx: 2'd1};
         DIG2:    sel = '{valid: 1'b1, idx: 2'd2};
         DIG3:    sel = '{valid: 1'b1, idx: 2'd3};
         default: sel = '{valid: 1'b0, idx: 2'd0};
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seven_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seven_seg_digit_driver.sv
// Drives segment cathodes and dp for the digit currently selected by the
// anode scanner. The display value is double-buffered and swapped only on
// the last digit of a frame, so a frame never mixes old and new digits.
module seven_seg_digit_driver
   import seven_seg_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        div_clock,
   input  logic        reset,
   input  logic [3:0]  anode_in,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        load,
   input  logic        blank_lead,
   output logic [3:0]  anode,
   output logic [6:0]  segment,
   output logic        dp,
   output logic        update_pending,
   output logic        fault
);

   // Output polarity masks: XOR with these turns active-low patterns into
   // the board's polarity. anode stays active-low regardless.
   localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
   localparam logic       DP_POL  = SEG_ACTIVE_LOW ? 1'b0  : 1'b1;

   // Shadow (written by load) and active (displayed) buffers.
   logic [15:0] shadow_val_q, shadow_val_d;
   logic [3:0]  shadow_dp_q,  shadow_dp_d;
   logic [15:0] active_val_q, active_val_d;
   logic [3:0]  active_dp_q,  active_dp_d;
   logic        pending_q,    pending_d;
   logic        fault_q,      fault_d;

   // Registered outputs, all launched on the same edge.
   logic [3:0]  anode_q,   anode_d;
   logic [6:0]  segment_q, segment_d;
   logic        dp_q,      dp_d;

   digit_sel_t  sel;
   logic        at_last;
   logic        bypass;
   logic        commit;
   logic [3:0]  cur_nib;
   logic [6:0]  hex_seg;
   logic [3:0]  lead_zero;
   logic        digit_blank;

   assign sel     = decode_anode(anode_in);
   assign at_last = sel.valid && (anode_in == DIG3);
   // A load on the frame's last digit goes straight to the active buffer.
   assign bypass  = at_last && load;
   assign commit  = at_last && pending_q && !load;

   // Nibble of the active value for the digit being scanned.
   assign cur_nib = active_val_q[{sel.idx, 2'b00} +: 4];

   // lead_zero[i] is set when digit i and every digit above it are zero.
   assign lead_zero[3] = (active_val_q[15:12] == 4'h0);
   assign lead_zero[2] = lead_zero[3] && (active_val_q[11:8] == 4'h0);
   assign lead_zero[1] = lead_zero[2] && (active_val_q[7:4]  == 4'h0);
   assign lead_zero[0] = lead_zero[1] && (active_val_q[3:0]  == 4'h0);

   // Digit 0 is never blanked so an all-zero value still reads "0".
   assign digit_blank = blank_lead && (sel.idx != 2'd0) && lead_zero[sel.idx];

   hex_to_seven_seg u_hex (
      .nibble_i (cur_nib),
      .seg_o    (hex_seg)
   );

   // Buffer next state: load into shadow, swap at the frame boundary.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      active_val_d = active_val_q;
      active_dp_d  = active_dp_q;
      pending_d    = pending_q;

      if (bypass) begin
         active_val_d = value;
         active_dp_d  = dp_in;
         pending_d    = 1'b0;
      end else begin
         if (commit) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
            pending_d    = 1'b0;
         end
         if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
         end
      end
   end

   // Output next state: selected digit's glyph, or everything dark on an
   // illegal anode code.
   always_comb begin
      anode_d   = ALL_OFF;
      segment_d = SEG_OFF ^ SEG_POL;
      dp_d      = 1'b1 ^ DP_POL;
      fault_d   = fault_q | ~sel.valid;

      if (sel.valid) begin
         anode_d   = anode_in;
         segment_d = (digit_blank ? SEG_OFF : hex_seg) ^ SEG_POL;
         dp_d      = ~active_dp_q[sel.idx] ^ DP_POL;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge div_clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      if (reset) begin
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         active_val_q <= '0;
         active_dp_q  <= '0;
         pending_q    <= 1'b0;
         fault_q      <= 1'b0;
         anode_q      <= ALL_OFF;
         segment_q    <= SEG_OFF ^ SEG_POL;
         dp_q         <= 1'b1 ^ DP_POL;
      end else begin
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         active_val_q <= active_val_d;
         active_dp_q  <= active_dp_d;
         pending_q    <= pending_d;
         fault_q      <= fault_d;
         anode_q      <= anode_d;
         segment_q    <= segment_d;
         dp_q         <= dp_d;
      end
   end

   assign anode          = anode_q;
   assign segment        = segment_q;
   assign dp             = dp_q;
   assign update_pending = pending_q;
   assign fault          = fault_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed bench for seven_seg_digit_driver. A reference model pushes the
// expected post-edge outputs when each cycle's stimulus is driven; they are
// popped and compared after the edge. A second instance with inverted
// segment polarity is checked against the bitwise inverse.
module tb_seven_seg_digit_driver;

   logic        div_clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  anode_in = 4'hF;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic        load = 1'b0;
   logic        blank_lead = 1'b0;

   logic [3:0]  anode, anode_n;
   logic [6:0]  segment, segment_n;
   logic        dp, dp_n;
   logic        update_pending, update_pending_n;
   logic        fault, fault_n;

   seven_seg_digit_driver #(.SEG_ACTIVE_LOW(1'b1)) dut (
      .div_clock(div_clock), .reset(reset), .anode_in(anode_in),
      .value(value), .dp_in(dp_in), .load(load), .blank_lead(blank_lead),
      .anode(anode), .segment(segment), .dp(dp),
      .update_pending(update_pending), .fault(fault)
   );

   seven_seg_digit_driver #(.SEG_ACTIVE_LOW(1'b0)) dut_inv (
      .div_clock(div_clock), .reset(reset), .anode_in(anode_in),
      .value(value), .dp_in(dp_in), .load(load), .blank_lead(blank_lead),
      .anode(anode_n), .segment(segment_n), .dp(dp_n),
      .update_pending(update_pending_n), .fault(fault_n)
   );

   always #5 div_clock = ~div_clock;

   typedef struct {
      logic [3:0] anode;
      logic [6:0] seg;
      logic       dp;
      logic       pend;
      logic       fault;
   } exp_t;

   exp_t sb[$];

   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   localparam logic [3:0] SCAN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Reference model state.
   logic [15:0] m_shadow_val = '0, m_active_val = '0;
   logic [3:0]  m_shadow_dp = '0,  m_active_dp = '0;
   logic        m_pend = 1'b0,     m_fault = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [6:0]  last_seg [4];

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One scan cycle: drive at negedge, predict, compare after posedge.
   task automatic step(input logic [3:0] ain, input logic ld = 1'b0, input logic rst = 1'b0);
      exp_t e;
      logic legal;
      int   idx;
      logic blank;
      @(negedge div_clock);
      anode_in = ain;
      load     = ld;
      reset    = rst;
      legal    = 1'b1;
      idx      = 0;
      case (ain)
         4'b1110: idx = 0;
         4'b1101: idx = 1;
         4'b1011: idx = 2;
         4'b0111: idx = 3;
         default: legal = 1'b0;
      endcase
      if (rst) begin
         e = '{4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
         m_shadow_val = '0; m_active_val = '0;
         m_shadow_dp  = '0; m_active_dp  = '0;
         m_pend = 1'b0; m_fault = 1'b0;
      end else begin
         if (!legal) begin
            e.anode = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
         end else begin
            blank   = blank_lead && (idx != 0) && ((m_active_val >> (idx * 4)) == 16'h0);
            e.anode = ain;
            e.seg   = blank ? 7'h7F : GLYPH[m_active_val[idx*4 +: 4]];
            e.dp    = ~m_active_dp[idx];
         end
         if (!legal) m_fault = 1'b1;
         if (legal && idx == 3 && ld) begin
            m_active_val = value; m_active_dp = dp_in; m_pend = 1'b0;
         end else begin
            if (legal && idx == 3 && m_pend) begin
               m_active_val = m_shadow_val; m_active_dp = m_shadow_dp; m_pend = 1'b0;
            end
            if (ld) begin
               m_shadow_val = value; m_shadow_dp = dp_in; m_pend = 1'b1;
            end
         end
         e.pend  = m_pend;
         e.fault = m_fault;
      end
      sb.push_back(e);
      @(posedge div_clock);
      #1;
      e = sb.pop_front();
      cyc++;
      check($sformatf("c%0d_anode", cyc), {3'b0, anode}, {3'b0, e.anode});
      check($sformatf("c%0d_seg", cyc), segment, e.seg);
      check($sformatf("c%0d_dp", cyc), {6'b0, dp}, {6'b0, e.dp});
      check($sformatf("c%0d_pend", cyc), {6'b0, update_pending}, {6'b0, e.pend});
      check($sformatf("c%0d_fault", cyc), {6'b0, fault}, {6'b0, e.fault});
      check($sformatf("c%0d_seg_inv", cyc), segment_n, ~e.seg);
      check($sformatf("c%0d_dp_inv", cyc), {6'b0, dp_n}, {6'b0, ~e.dp});
      if (legal && !rst) last_seg[idx] = segment;
   endtask

   // One full frame; load is pulsed on slot load_slot (-1 = none).
   task automatic frame(input int load_slot = -1);
      for (int i = 0; i < 4; i++) step(SCAN[i], (i == load_slot));
   endtask

   initial begin
      step(4'hF, 1'b0, 1'b1);
      step(4'hF, 1'b0, 1'b1);
      frame();
      for (int i = 0; i < 4; i++) check($sformatf("rst_d%0d", i), last_seg[i], 7'b1000000);

      // Load mid-frame; shown from the next frame.
      value = 16'h12AF;
      frame(1);
      frame();
      check("hex_d0", last_seg[0], 7'b0001110);
      check("hex_d1", last_seg[1], 7'b0001000);
      check("hex_d2", last_seg[2], 7'b0100100);
      check("hex_d3", last_seg[3], 7'b1111001);

      // Leading-zero blanking.
      blank_lead = 1'b1;
      value = 16'h0030;
      frame(0);
      frame();
      check("blank_d3", last_seg[3], 7'b1111111);
      check("blank_d2", last_seg[2], 7'b1111111);
      check("blank_d1", last_seg[1], 7'b0110000);
      check("blank_d0", last_seg[0], 7'b1000000);
      value = 16'h0000;
      frame(2);
      frame();
      check("zero_d3", last_seg[3], 7'b1111111);
      check("zero_d1", last_seg[1], 7'b1111111);
      check("zero_d0", last_seg[0], 7'b1000000);
      blank_lead = 1'b0;

      // Load coinciding with the commit slot bypasses the shadow.
      value = 16'hBEEF;
      frame(3);
      check("bypass_pend", {6'b0, update_pending}, 7'd0);
      frame();
      check("bypass_d0", last_seg[0], 7'b0001110);
      check("bypass_d1", last_seg[1], 7'b0000110);
      check("bypass_d3", last_seg[3], 7'b0000011);

      // Two loads before commit: last one wins.
      value = 16'h1111;
      step(SCAN[0], 1'b1);
      value = 16'h2222;
      step(SCAN[1], 1'b1);
      step(SCAN[2]);
      step(SCAN[3]);
      frame();
      for (int i = 0; i < 4; i++) check($sformatf("last_load_d%0d", i), last_seg[i], 7'b0100100);

      // Illegal anode code: dark outputs and sticky fault.
      step(4'b1100);
      check("illegal_seg", segment, 7'b1111111);
      check("illegal_anode", {3'b0, anode}, 7'h0F);
      frame();
      check("fault_sticky", {6'b0, fault}, 7'd1);

      // Decimal point follows its own digit only.
      value = 16'h1234;
      dp_in = 4'b0100;
      frame(0);
      dp_in = 4'b0000;
      frame();

      // Reset mid-frame discards a pending update.
      value = 16'h5555;
      step(SCAN[0], 1'b1);
      step(SCAN[1], 1'b0, 1'b1);
      check("rst_pend", {6'b0, update_pending}, 7'd0);
      frame();
      frame();
      for (int i = 0; i < 4; i++) check($sformatf("rst_drop_d%0d", i), last_seg[i], 7'b1000000);
      check("rst_fault", {6'b0, fault}, 7'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
